// File: rtl/doodle_game_ctrl.sv
// Doodle-jump game controller: frame-paced FSM driving ball physics, world scroll and scoring.
// Latency: state acts on the third Clk edge after a frame_clk rise; scroll_en follows ball_update by one cycle.
// No backpressure: ball_update/scroll_en are single-cycle fire-and-forget pulses.
module doodle_game_ctrl #(
  parameter logic [9:0] SCROLL_LINE = 10'd160,
  parameter logic [9:0] SCROLL_MAX  = 10'd8,
  parameter logic [7:0] START_KEY   = 8'h2C
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        frame_clk,
  input  logic [7:0]  keycode,
  input  logic [9:0]  BallY,
  output logic        ball_update,
  output logic        scroll_en,
  output logic [9:0]  scroll_amt,
  output logic [15:0] score,
  output logic [15:0] hi_score,
  output logic [1:0]  state,
  output logic        game_over
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PLAY   = 2'd1,
    SCROLL = 2'd2,
    OVER   = 2'd3
  } state_t;

  state_t cur_state;
  state_t nxt_state;

  // frame_clk synchroniser, edge detector and post-reset arming
  logic sync1;
  logic sync2;
  logic sync3;
  logic settle;
  logic armed;
  logic frame_tick;

  // Combinational decode of the current frame sample
  logic        fall_off;
  logic        above_line;
  logic [9:0]  gap;
  logic        ball_nxt;
  logic [9:0]  amt_nxt;
  logic [16:0] score_sum;
  logic [15:0] score_sat;

  assign state      = cur_state;
  assign fall_off   = (BallY >= 10'd480);
  assign above_line = (BallY < SCROLL_LINE);
  assign gap        = SCROLL_LINE - BallY;

  // A rise seen on frame_clk only counts once the line has been observed low after reset,
  // so a frame_clk already high at deassertion cannot fake a tick.
  assign frame_tick = armed & sync2 & ~sync3;

  // Two-flop synchroniser plus history flop; armed once a post-reset low level is sampled
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      sync3  <= 1'b0;
      settle <= 1'b0;
      armed  <= 1'b0;
    end else begin
      sync1  <= frame_clk;
      sync2  <= sync1;
      sync3  <= sync2;
      settle <= 1'b1;
      if (settle && !sync1) begin
        armed <= 1'b1;
      end
    end
  end

  // FSM state register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cur_state <= IDLE;
    end else begin
      cur_state <= nxt_state;
    end
  end

  // FSM next-state logic; inputs are only looked at on the frame_tick cycle
  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      IDLE: begin
        if (frame_tick && (keycode == START_KEY)) begin
          nxt_state = PLAY;
        end
      end
      PLAY: begin
        if (frame_tick) begin
          if (fall_off) begin
            nxt_state = OVER;
          end else if (above_line) begin
            nxt_state = SCROLL;
          end else begin
            nxt_state = PLAY;
          end
        end
      end
      SCROLL: begin
        nxt_state = PLAY;
      end
      OVER: begin
        // Requiring key release stops a held start key from skipping the game-over screen
        if (frame_tick && (keycode == 8'h00)) begin
          nxt_state = IDLE;
        end
      end
      default: begin
        nxt_state = IDLE;
      end
    endcase
  end

  // FSM output decode: next values for the registered pulses and datapath
  always_comb begin
    game_over = (cur_state == OVER);
    ball_nxt  = frame_tick && (cur_state == PLAY) && !fall_off;
    amt_nxt   = (gap > SCROLL_MAX) ? SCROLL_MAX : gap;
    score_sum = {1'b0, score} + {7'd0, scroll_amt};
    score_sat = score_sum[16] ? 16'hFFFF : score_sum[15:0];
  end

  // Registered pulses, scroll distance, score and high score
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ball_update <= 1'b0;
      scroll_en   <= 1'b0;
      scroll_amt  <= 10'd0;
      score       <= 16'd0;
      hi_score    <= 16'd0;
    end else begin
      ball_update <= ball_nxt;
      // scroll_en lands in the cycle after SCROLL, never overlapping ball_update
      scroll_en   <= (cur_state == SCROLL);
      if ((cur_state == PLAY) && (nxt_state == SCROLL)) begin
        scroll_amt <= amt_nxt;
      end
      if ((cur_state == IDLE) && (nxt_state == PLAY)) begin
        score <= 16'd0;
      end else if (cur_state == SCROLL) begin
        score <= score_sat;
      end
      if ((cur_state == PLAY) && (nxt_state == OVER) && (score > hi_score)) begin
        hi_score <= score;
      end
    end
  end

endmodule

// File: tb/tb_doodle_game_ctrl.sv
// Self-checking bench for doodle_game_ctrl: directed frames with a pulse scoreboard.
// Latency: one frame per 7 Clk cycles; expected pulses queued at stimulus time.
// No backpressure in the DUT; the monitor pops one entry per observed pulse.
module tb_doodle_game_ctrl;

  logic        Clk;
  logic        Reset_n;
  logic        frame_clk;
  logic [7:0]  keycode;
  logic [9:0]  BallY;
  logic        ball_update;
  logic        scroll_en;
  logic [9:0]  scroll_amt;
  logic [15:0] score;
  logic [15:0] hi_score;
  logic [1:0]  state;
  logic        game_over;

  typedef struct {
    bit          is_scroll;
    logic [9:0]  amt;
    logic [15:0] sc;
  } ev_t;

  ev_t         sb[$];
  ev_t         mon_ev;
  int          tests = 0;
  int          fails = 0;
  logic [15:0] exp_score = 16'd0;
  logic [15:0] exp_hi = 16'd0;
  logic [1:0]  exp_state = 2'd0;
  int          cnt;

  doodle_game_ctrl dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .frame_clk   (frame_clk),
    .keycode     (keycode),
    .BallY       (BallY),
    .ball_update (ball_update),
    .scroll_en   (scroll_en),
    .scroll_amt  (scroll_amt),
    .score       (score),
    .hi_score    (hi_score),
    .state       (state),
    .game_over   (game_over)
  );

  initial begin
    Clk = 1'b0;
    forever #10 Clk = ~Clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One frame_clk period: 3 Clk high, 4 Clk low
  task automatic frame();
    @(negedge Clk);
    frame_clk = 1'b1;
    repeat (3) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (3) @(negedge Clk);
  endtask

  task automatic check_status(input string tag);
    check({tag, "_state"}, 32'(state), 32'(exp_state));
    check({tag, "_score"}, 32'(score), 32'(exp_score));
    check({tag, "_hi"}, 32'(hi_score), 32'(exp_hi));
    check({tag, "_over"}, 32'(game_over), 32'(exp_state == 2'd3));
  endtask

  task automatic play_frame(input logic [9:0] y);
    ev_t ev;
    int  d;
    int  sum;
    BallY = y;
    if (y >= 10'd480) begin
      if (exp_score > exp_hi) exp_hi = exp_score;
      exp_state = 2'd3;
    end else begin
      ev.is_scroll = 1'b0;
      ev.amt = 10'd0;
      ev.sc = 16'd0;
      sb.push_back(ev);
      if (y < 10'd160) begin
        d = 160 - int'(y);
        if (d > 8) d = 8;
        sum = int'(exp_score) + d;
        exp_score = (sum > 65535) ? 16'hFFFF : 16'(sum);
        ev.is_scroll = 1'b1;
        ev.amt = 10'(d);
        ev.sc = exp_score;
        sb.push_back(ev);
      end
      exp_state = 2'd1;
    end
    frame();
    check_status("play");
  endtask

  task automatic ctl_frame(input logic [7:0] k, input logic [1:0] es);
    keycode = k;
    frame();
    if (exp_state == 2'd0 && es == 2'd1) exp_score = 16'd0;
    exp_state = es;
    check_status("ctl");
  endtask

  // Scoreboard monitor: every pulse must match the next queued expectation
  always @(negedge Clk) begin
    if (Reset_n === 1'b1) begin
      if (ball_update && scroll_en) check("pulse_overlap", 32'd1, 32'd0);
      if (ball_update || scroll_en) begin
        if (sb.size() == 0) begin
          check("unexpected_pulse", 32'({ball_update, scroll_en}), 32'd0);
        end else begin
          mon_ev = sb.pop_front();
          check("pulse_kind", 32'(scroll_en), 32'(mon_ev.is_scroll));
          if (mon_ev.is_scroll) begin
            check("scroll_amt", 32'(scroll_amt), 32'(mon_ev.amt));
            check("scroll_score", 32'(score), 32'(mon_ev.sc));
          end
        end
      end
    end
  end

  initial begin
    Reset_n   = 1'b0;
    frame_clk = 1'b1;
    keycode   = 8'h2C;
    BallY     = 10'd200;
    repeat (2) @(negedge Clk);
    check("rst_state", 32'(state), 32'd0);
    check("rst_ball", 32'(ball_update), 32'd0);
    check("rst_scroll", 32'(scroll_en), 32'd0);
    check("rst_amt", 32'(scroll_amt), 32'd0);
    check("rst_score", 32'(score), 32'd0);
    check("rst_hi", 32'(hi_score), 32'd0);
    check("rst_over", 32'(game_over), 32'd0);

    // frame_clk already high at release must not produce a tick
    Reset_n = 1'b1;
    repeat (8) @(negedge Clk);
    check("no_tick_after_rst", 32'(state), 32'd0);
    frame_clk = 1'b0;
    repeat (3) @(negedge Clk);

    // Start: measure latency from frame_clk rise to PLAY
    @(negedge Clk);
    frame_clk = 1'b1;
    cnt = 0;
    while (state !== 2'd1 && cnt < 10) begin
      @(posedge Clk);
      #1;
      cnt++;
    end
    check("start_latency", 32'(cnt >= 3 && cnt <= 4), 32'd1);
    frame_clk = 1'b0;
    repeat (4) @(negedge Clk);
    exp_state = 2'd1;
    exp_score = 16'd0;
    check_status("start");

    // First game: normal, clamped and unclamped scrolls up to 25
    play_frame(10'd200);
    play_frame(10'd100);
    play_frame(10'd155);
    check("amt_hold", 32'(scroll_amt), 32'd5);
    play_frame(10'd100);
    play_frame(10'd156);
    play_frame(10'd480);

    // Restart and reach 40, fall off: hi score rises from 25 to 40
    ctl_frame(8'h00, 2'd0);
    ctl_frame(8'h2C, 2'd1);
    repeat (5) play_frame(10'd100);
    play_frame(10'd480);

    // Held start key cannot leave OVER; release then press restarts
    ctl_frame(8'h2C, 2'd3);
    ctl_frame(8'h2C, 2'd3);
    ctl_frame(8'h2C, 2'd3);
    ctl_frame(8'h00, 2'd0);
    ctl_frame(8'h2C, 2'd1);

    // Lower score game over: hi score holds
    play_frame(10'd490);
    ctl_frame(8'h00, 2'd0);
    ctl_frame(8'h2C, 2'd1);

    // Saturation: climb to 0xFFFC, then scrolls pin at 0xFFFF
    for (int i = 0; i < 8191; i++) play_frame(10'd100);
    play_frame(10'd156);
    check("sat_pre", 32'(score), 32'hFFFC);
    play_frame(10'd100);
    check("sat_hit", 32'(score), 32'hFFFF);
    play_frame(10'd100);
    check("sat_hold", 32'(score), 32'hFFFF);

    // Async reset during the SCROLL cycle
    BallY = 10'd100;
    @(negedge Clk);
    frame_clk = 1'b1;
    cnt = 0;
    while (state !== 2'd2 && cnt < 10) begin
      @(posedge Clk);
      #1;
      cnt++;
    end
    check("mid_scroll_state", 32'(state), 32'd2);
    check("mid_scroll_ball", 32'(ball_update), 32'd1);
    Reset_n = 1'b0;
    #1;
    check("arst_state", 32'(state), 32'd0);
    check("arst_ball", 32'(ball_update), 32'd0);
    check("arst_scroll", 32'(scroll_en), 32'd0);
    check("arst_amt", 32'(scroll_amt), 32'd0);
    check("arst_score", 32'(score), 32'd0);
    check("arst_hi", 32'(hi_score), 32'd0);
    check("arst_over", 32'(game_over), 32'd0);
    frame_clk = 1'b0;
    repeat (3) begin
      @(negedge Clk);
      check("arst_no_scroll", 32'(scroll_en), 32'd0);
    end
    Reset_n = 1'b1;
    repeat (4) @(negedge Clk);
    check("arst_score_after", 32'(score), 32'd0);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/doodle_game_ctrl.md
DOODLE_GAME_CTRL -- requirements
Module: doodle_game_ctrl

Interface
REQ-001 SHALL have parameter SCROLL_LINE, default 10'd160: screen row above which the world scrolls.
REQ-002 SHALL have parameter SCROLL_MAX, default 10'd8: maximum scroll pixels per frame.
REQ-003 SHALL have parameter START_KEY, default 8'h2C: USB keycode for the space bar, used to start and restart.
REQ-004 SHALL have port Clk, input, 1: 50 MHz system clock (MAX10_CLK1_50).
REQ-005 SHALL have port Reset_n, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port frame_clk, input, 1: VGA_VS, asynchronous to Clk.
REQ-007 SHALL have port keycode, input, 8: current USB keycode.
REQ-008 SHALL have port BallY, input, 10: doodler top row.
REQ-009 SHALL have port ball_update, output, 1: one-cycle pulse that enables one physics step in ball.
REQ-010 SHALL have port scroll_en, output, 1: one-cycle pulse; platforms shift down by scroll_amt.
REQ-011 SHALL have port scroll_amt, output, 10: scroll distance, valid while scroll_en=1.
REQ-012 SHALL have port score, output, 16: current score.
REQ-013 SHALL have port hi_score, output, 16: best score since reset.
REQ-014 SHALL have port state, output, 2: IDLE=0, PLAY=1, SCROLL=2, OVER=3.
REQ-015 SHALL have port game_over, output, 1: high while state=OVER.

Function
REQ-016 SHALL synchronise frame_clk through two flops and rising-edge detect it into frame_tick, a one-Clk pulse 3 Clk cycles after the frame_clk rise.
REQ-017 SHALL sample keycode and BallY only on the frame_tick cycle; outside that cycle, state changes only for SCROLL->PLAY.
REQ-018 IDLE transition: on frame_tick with keycode==START_KEY, go to PLAY and clear score to 0 in the same edge; otherwise hold.
REQ-019 PLAY, fall-off: on frame_tick with BallY>=10'd480, go to OVER and do not pulse ball_update.
REQ-020 PLAY, scroll: otherwise, on frame_tick with BallY<SCROLL_LINE, pulse ball_update, latch scroll_amt=min(SCROLL_LINE-BallY, SCROLL_MAX), and go to SCROLL.
REQ-021 PLAY, normal: otherwise, on frame_tick, pulse ball_update and stay in PLAY.
REQ-022 Fall-off SHALL take priority over scroll when both conditions hold.
REQ-023 SCROLL SHALL last exactly one cycle: assert scroll_en, add scroll_amt to score, return to PLAY unconditionally.
REQ-024 Score arithmetic SHALL be unsigned and saturate at 16'hFFFF, with no wrap-around.
REQ-025 Entering OVER SHALL set hi_score=score when score>hi_score; on equal or lower score, hi_score holds.
REQ-026 OVER SHALL hold score and game_over=1; on frame_tick with keycode==8'h00 (key released), go to IDLE.
REQ-027 OVER->IDLE SHALL require key release, so a held START_KEY cannot skip the OVER screen.
REQ-028 A frame_tick arriving while in SCROLL is impossible (ticks are over 800k cycles apart) and needs no handling.
REQ-029 ball_update and scroll_en SHALL be registered outputs and SHALL never be high in the same cycle.
REQ-030 scroll_amt SHALL hold its last value when scroll_en=0.

Reset
REQ-031 Reset_n=0 SHALL immediately force state=IDLE, ball_update=0, scroll_en=0, scroll_amt=0, score=0, hi_score=0, game_over=0, and clear the synchroniser flops.
REQ-032 Reset asserted mid-SCROLL SHALL suppress the scroll_en pulse and leave score unchanged at 0.
REQ-033 After Reset_n rises, the first frame_tick SHALL occur only on a frame_clk rise that happens after deassertion.

Verification
REQ-034 Start: IDLE, keycode=8'h2C, one frame_clk rise -> state=PLAY 3-4 cycles later, score=0, no ball_update on that tick.
REQ-035 Scroll clamp: PLAY, BallY=100 -> ball_update pulse, then scroll_en for one cycle with scroll_amt=8, score +8; with BallY=155 -> scroll_amt=5.
REQ-036 Fall-off priority and high score: PLAY, score=40, hi_score=25, BallY=480 -> state=OVER, no ball_update, hi_score=40, game_over=1.
REQ-037 Restart gating: OVER, keycode held at 8'h2C for 3 frames -> stays OVER; keycode=0 on next frame -> IDLE; 8'h2C on the following frame -> PLAY, score=0, hi_score=40.
REQ-038 Saturation: score=16'hFFFC, scroll_amt=8 -> score=16'hFFFF and stays 16'hFFFF on further scrolls.
REQ-039 Async reset: drop Reset_n in the SCROLL cycle -> no scroll_en pulse, all outputs 0, state=IDLE without a Clk edge.
